// File: rtl/zed64_vram_pkg.sv
// Shared VRAM definitions for the zed64 video subsystem.
// Holds the bus widths, the memory map bases and the arbiter state encoding.
package zed64_vram_pkg;

    localparam int VRAM_AW = 16;
    localparam int VRAM_DW = 8;

    localparam logic [VRAM_AW-1:0] CHAR_BASE = 16'h8000;
    localparam logic [VRAM_AW-1:0] FONT_BASE = 16'hC000;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ISSUED = 2'd1,
        ARB_RDWAIT = 2'd2,
        ARB_ACK    = 2'd3
    } arb_state_t;

    // CPU may take the bus when gating is off, or during any blanking interval.
    function automatic logic cpu_gate_open(input logic blank_only,
                                           input logic hblank,
                                           input logic vblank);
        return (!blank_only) || hblank || vblank;
    endfunction

endpackage

// File: rtl/vram_arbiter_stats.sv
// Saturating counter of CPU stall cycles for the VRAM arbiter.
// Only instantiated when VRAM_ARB_STATS_EN is defined.
module vram_arb_stats (
    input  logic        pixel_clock,
    input  logic        reset,
    input  logic        clr,
    input  logic        stall,
    output logic [15:0] count
);

    // Count stalled cycles, sticking at all-ones; clear has priority over counting.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            count <= 16'h0000;
        end else if (clr) begin
            count <= 16'h0000;
        end else if (stall && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch slots always win, the CPU is served in free cycles.
// Optional stall statistics are built when VRAM_ARB_STATS_EN is defined.
module vram_arbiter
    import zed64_vram_pkg::*;
#(
    parameter bit CPU_BLANK_ONLY = 1'b0
) (
    input  logic               pixel_clock,
    input  logic               reset,
    input  logic               hblank,
    input  logic               vblank,
    input  logic               vid_req,
    input  logic [VRAM_AW-1:0] vid_addr,
    output logic [VRAM_DW-1:0] vid_rdata,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [VRAM_AW-1:0] cpu_addr,
    input  logic [VRAM_DW-1:0] cpu_wdata,
    output logic               cpu_ack,
    output logic [VRAM_DW-1:0] cpu_rdata,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic               vram_we,
    output logic [VRAM_DW-1:0] vram_wdata,
    input  logic [VRAM_DW-1:0] vram_rdata
`ifdef VRAM_ARB_STATS_EN
    ,
    input  logic               stats_clr,
    output logic [15:0]        stall_count
`endif
);

    arb_state_t state_r;
    arb_state_t state_nxt_s;
    logic       issue_s;
    logic       ack_nxt_s;
    logic       wr_r;

    assign vid_rdata = vram_rdata;

    // Next-state and issue decision; ACK is never a new request, only IDLE may issue.
    always_comb begin
        issue_s     = 1'b0;
        ack_nxt_s   = 1'b0;
        state_nxt_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (cpu_req && !vid_req && cpu_gate_open(CPU_BLANK_ONLY, hblank, vblank)) begin
                    issue_s     = 1'b1;
                    state_nxt_s = ARB_ISSUED;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_ISSUED: begin
                if (wr_r) begin
                    ack_nxt_s   = 1'b1;
                    state_nxt_s = ARB_ACK;
                end else begin
                    state_nxt_s = ARB_RDWAIT;
                end
            end
            ARB_RDWAIT: begin
                ack_nxt_s   = 1'b1;
                state_nxt_s = ARB_ACK;
            end
            ARB_ACK: begin
                state_nxt_s = ARB_IDLE;
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // FSM state register and latched transaction direction.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state_r <= ARB_IDLE;
            wr_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            wr_r    <= issue_s ? cpu_we : wr_r;
        end
    end

    // Registered VRAM bus: video owns the address whenever it asks, in any FSM state.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            vram_addr  <= '0;
            vram_we    <= 1'b0;
            vram_wdata <= '0;
        end else if (vid_req) begin
            vram_addr  <= vid_addr;
            vram_we    <= 1'b0;
        end else if (issue_s) begin
            vram_addr  <= cpu_addr;
            vram_we    <= cpu_we;
            vram_wdata <= cpu_wdata;
        end else begin
            vram_we    <= 1'b0;
        end
    end

    // Read data is taken in RDWAIT, i.e. one cycle after the CPU address was on the bus,
    // so a video slot that follows the issue cannot corrupt it.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            cpu_ack   <= ack_nxt_s;
            cpu_rdata <= (state_r == ARB_RDWAIT) ? vram_rdata : cpu_rdata;
        end
    end

`ifdef VRAM_ARB_STATS_EN
    logic stall_s;

    assign stall_s = (state_r == ARB_IDLE) && cpu_req && !issue_s;

    vram_arb_stats u_stats (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .clr         (stats_clr),
        .stall       (stall_s),
        .count       (stall_count)
    );
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: a table of cycle vectors plus directed multi-cycle sequences.
// Two instances: CPU_BLANK_ONLY=0 (dut0) and CPU_BLANK_ONLY=1 (dut1), each with its own VRAM model.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hblank = 1'b1;
    logic        vblank = 1'b0;
    logic        vid_req = 1'b0;
    logic [15:0] vid_addr = 16'h0000;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        stats_clr = 1'b0;

    logic [7:0]  vid_rdata0, vid_rdata1, cpu_rdata0, cpu_rdata1, vram_wdata0, vram_wdata1;
    logic [7:0]  vram_rdata0, vram_rdata1;
    logic        cpu_ack0, cpu_ack1, vram_we0, vram_we1;
    logic [15:0] vram_addr0, vram_addr1;
    logic [15:0] stall0, stall1;

    logic [7:0]  mem0 [0:65535];
    logic [7:0]  mem1 [0:65535];
    logic        ld_en = 1'b0;
    logic [15:0] ld_addr = 16'h0000;
    logic [7:0]  ld_data = 8'h00;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.CPU_BLANK_ONLY(1'b0)) dut0 (
        .pixel_clock(clk), .reset(reset), .hblank(hblank), .vblank(vblank),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata0),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack0), .cpu_rdata(cpu_rdata0),
        .vram_addr(vram_addr0), .vram_we(vram_we0), .vram_wdata(vram_wdata0),
        .vram_rdata(vram_rdata0)
`ifdef VRAM_ARB_STATS_EN
        , .stats_clr(stats_clr), .stall_count(stall0)
`endif
    );

    vram_arbiter #(.CPU_BLANK_ONLY(1'b1)) dut1 (
        .pixel_clock(clk), .reset(reset), .hblank(hblank), .vblank(vblank),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata1),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack1), .cpu_rdata(cpu_rdata1),
        .vram_addr(vram_addr1), .vram_we(vram_we1), .vram_wdata(vram_wdata1),
        .vram_rdata(vram_rdata1)
`ifdef VRAM_ARB_STATS_EN
        , .stats_clr(stats_clr), .stall_count(stall1)
`endif
    );

`ifndef VRAM_ARB_STATS_EN
    assign stall0 = 16'h0000;
    assign stall1 = 16'h0000;
`endif

    // Synchronous single-port VRAM models with one-cycle read latency.
    always @(posedge clk) begin
        if (ld_en) begin
            mem0[ld_addr] <= ld_data;
            mem1[ld_addr] <= ld_data;
        end else begin
            if (vram_we0) mem0[vram_addr0] <= vram_wdata0;
            if (vram_we1) mem1[vram_addr1] <= vram_wdata1;
        end
        vram_rdata0 <= mem0[vram_addr0];
        vram_rdata1 <= mem1[vram_addr1];
    end

    typedef struct {
        logic        rst;
        logic        blank;
        logic        vreq;
        logic [15:0] vaddr;
        logic        creq;
        logic        cwe;
        logic [15:0] caddr;
        logic [7:0]  cwd;
        logic [15:0] e_addr;
        logic        e_we;
        logic        e_ack;
        logic [7:0]  e_rd;
        logic        chk_v;
        logic [7:0]  e_vrd;
    } vec_t;

    vec_t vecs [0:19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic req(input logic r, input logic we, input logic [15:0] a, input logic [7:0] d);
        cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    // Ticks until the selected instance acks; n = samples taken (budget-bounded).
    task automatic wait_ack(input int which, output int n);
        n = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if ((which == 0 && cpu_ack0) || (which == 1 && cpu_ack1)) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int bad;

        //        rst   blank vreq  vaddr     creq  cwe   caddr     cwd     e_addr    e_we  e_ack e_rd   chk_v e_vrd
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h8010, 8'h00, 16'h8010, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h8010, 8'h00, 16'h8010, 1'b0, 1'b0, 8'h00, 1'b1, 8'h41};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h8010, 8'h00, 16'h8010, 1'b0, 1'b1, 8'h41, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h8010, 8'h00, 16'h8010, 1'b0, 1'b0, 8'h41, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h8010, 8'h00, 16'h8010, 1'b0, 1'b0, 8'h41, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h8010, 8'h00, 16'h8010, 1'b0, 1'b0, 8'h41, 1'b0, 8'h00};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'h8001, 1'b1, 1'b1, 16'hC008, 8'h5A, 16'h8001, 1'b0, 1'b0, 8'h41, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'h8001, 1'b1, 1'b1, 16'hC008, 8'h5A, 16'hC008, 1'b1, 1'b0, 8'h41, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h8001, 1'b1, 1'b1, 16'hC008, 8'h5A, 16'hC008, 1'b0, 1'b1, 8'h41, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h8001, 1'b0, 1'b0, 16'hC008, 8'h00, 16'hC008, 1'b0, 1'b0, 8'h41, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 16'h8001, 1'b1, 1'b0, 16'hC008, 8'h00, 16'hC008, 1'b0, 1'b0, 8'h41, 1'b0, 8'h00};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 16'h8001, 1'b1, 1'b0, 16'hC008, 8'h00, 16'hC008, 1'b0, 1'b0, 8'h41, 1'b1, 8'h5A};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 16'h8001, 1'b1, 1'b0, 16'hC008, 8'h00, 16'hC008, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h00};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 16'h8001, 1'b0, 1'b0, 16'hC008, 8'h00, 16'hC008, 1'b0, 1'b0, 8'h5A, 1'b0, 8'h00};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 16'h8001, 1'b1, 1'b0, 16'h4000, 8'h00, 16'h4000, 1'b0, 1'b0, 8'h5A, 1'b0, 8'h00};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 16'hC123, 1'b1, 1'b0, 16'h4000, 8'h00, 16'hC123, 1'b0, 1'b0, 8'h5A, 1'b1, 8'h33};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 16'hC123, 1'b1, 1'b0, 16'h4000, 8'h00, 16'hC123, 1'b0, 1'b1, 8'h33, 1'b1, 8'h77};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 16'hC123, 1'b0, 1'b0, 16'h4000, 8'h00, 16'hC123, 1'b0, 1'b0, 8'h33, 1'b0, 8'h00};

        load(16'h8010, 8'h41);
        load(16'h4000, 8'h33);
        load(16'hC123, 8'h77);
        load(16'hC008, 8'h00);

        // Table: inputs of row i are held for one cycle; expectations hold after that edge.
        for (int i = 0; i < 20; i++) begin
            reset = vecs[i].rst; hblank = vecs[i].blank; vblank = 1'b0;
            vid_req = vecs[i].vreq; vid_addr = vecs[i].vaddr;
            req(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd);
            tick();
            chk($sformatf("v%0d_addr0", i), vram_addr0, vecs[i].e_addr);
            chk($sformatf("v%0d_we0", i), vram_we0, vecs[i].e_we);
            chk($sformatf("v%0d_ack0", i), cpu_ack0, vecs[i].e_ack);
            chk($sformatf("v%0d_rd0", i), cpu_rdata0, vecs[i].e_rd);
            chk($sformatf("v%0d_addr1", i), vram_addr1, vecs[i].e_addr);
            chk($sformatf("v%0d_ack1", i), cpu_ack1, vecs[i].e_ack);
            chk($sformatf("v%0d_rd1", i), cpu_rdata1, vecs[i].e_rd);
            if (vecs[i].chk_v) chk($sformatf("v%0d_vrd0", i), vid_rdata0, vecs[i].e_vrd);
        end

        // Blank-only gating: request during the active line, released by a one-cycle hblank.
        reset = 1'b1; req(1'b0, 1'b0, 16'h0000, 8'h00); vid_req = 1'b0; tick();
        reset = 1'b0; hblank = 1'b0; vblank = 1'b0;
        req(1'b1, 1'b0, 16'h8010, 8'h00);
        bad = 0;
        for (int h = 100; h < 1024; h++) begin
            tick();
            if (cpu_ack1 || vram_addr1 != 16'h0000) bad++;
        end
        chk("gate_closed_cycles", bad, 0);
        hblank = 1'b1;
        tick();
        chk("gate_issue_addr", vram_addr1, 16'h8010);
        hblank = 1'b0;
        wait_ack(1, n);
        chk("gate_ack_latency", n + 1, 3);
        chk("gate_rdata", cpu_rdata1, 8'h41);
        req(1'b0, 1'b0, 16'h0000, 8'h00);
        hblank = 1'b1;

        // Reset in RDWAIT: no ack afterwards, bus back to reset values.
        reset = 1'b1; tick(); reset = 1'b0;
        req(1'b1, 1'b0, 16'h8010, 8'h00);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rst_rd_ack", cpu_ack0, 1'b0);
        chk("rst_rd_we", vram_we0, 1'b0);
        chk("rst_rd_addr", vram_addr0, 16'h0000);
        reset = 1'b0; req(1'b0, 1'b0, 16'h0000, 8'h00);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (cpu_ack0 || cpu_ack1) bad++;
        end
        chk("rst_rd_no_ack", bad, 0);

        // Reset while the write strobe is on the bus clears it at the next edge.
        req(1'b1, 1'b1, 16'h4000, 8'h99);
        tick();
        chk("wr_strobe", vram_we0, 1'b1);
        reset = 1'b1;
        tick();
        chk("rst_wr_we", vram_we0, 1'b0);
        chk("rst_wr_ack", cpu_ack0, 1'b0);
        reset = 1'b0;

        // Re-request completes normally.
        req(1'b1, 1'b0, 16'h8010, 8'h00);
        tick();
        chk("rereq_addr", vram_addr0, 16'h8010);
        wait_ack(0, n);
        chk("rereq_latency", n + 1, 3);
        chk("rereq_rdata", cpu_rdata0, 8'h41);
        req(1'b0, 1'b0, 16'h0000, 8'h00);
        tick();

`ifdef VRAM_ARB_STATS_EN
        reset = 1'b1; tick(); reset = 1'b0;
        chk("stats_reset", stall0, 16'h0000);
        vid_req = 1'b1; hblank = 1'b0;
        req(1'b1, 1'b0, 16'h8010, 8'h00);
        for (int k = 0; k < 5; k++) tick();
        vid_req = 1'b0; req(1'b0, 1'b0, 16'h0000, 8'h00);
        tick();
        chk("stats_five0", stall0, 16'd5);
        chk("stats_five1", stall1, 16'd5);
        stats_clr = 1'b1; tick(); stats_clr = 1'b0;
        chk("stats_clr", stall0, 16'h0000);
        vid_req = 1'b1; req(1'b1, 1'b0, 16'h8010, 8'h00);
        for (int k = 0; k < 65540; k++) tick();
        chk("stats_sat", stall0, 16'hFFFF);
        tick();
        chk("stats_sat_hold", stall0, 16'hFFFF);
        vid_req = 1'b0; req(1'b0, 1'b0, 16'h0000, 8'h00); hblank = 1'b1;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
